processor_stage2_v2: RTL and testbench

//  Operand-fetch stage, 2nd generation: register read with N-port forwarding, load-use interlock,

---
 rtl/processor_pkg.sv | 32 +++
 rtl/processor_stage2_v2_fwd_select.sv | 24 ++
 rtl/processor_stage2_v2_if_control.sv | 30 +++
 rtl/processor_stage2_v2.sv | 171 +++++++++++++++++
 tb/tb_processor_stage2_v2.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/processor_pkg.sv
// Opcode map, stage-2 state encoding and operand-usage helpers shared by the
// operand-fetch stage and its sub-modules.
package processor_pkg;

  localparam logic [3:0] OP_ALU        = 4'h1;
  localparam logic [3:0] OP_LOAD       = 4'h2;
  localparam logic [3:0] OP_WRITE      = 4'h3;
  localparam logic [3:0] OP_IF         = 4'h4;
  localparam logic [3:0] OP_CALL_IMM14 = 4'h5;
  localparam logic [3:0] OP_RETURN     = 4'h6;
  localparam logic [3:0] OP_WAIT       = 4'h7;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_WAIT_TIMED = 2'd1;
  localparam logic [1:0] ST_WAIT_EVENT = 2'd2;

  typedef enum logic [1:0] {
    RUN        = ST_RUN,
    WAIT_TIMED = ST_WAIT_TIMED,
    WAIT_EVENT = ST_WAIT_EVENT
  } stage2_state_t;

  // Which read ports an opcode actually consumes; only these can trip the load-use interlock.
  function automatic logic uses_port0(input logic [3:0] op);
    return op inside {OP_ALU, OP_WRITE, OP_IF};
  endfunction

  function automatic logic uses_port1(input logic [3:0] op);
    return op inside {OP_ALU, OP_LOAD, OP_WRITE, OP_CALL_IMM14, OP_RETURN};
  endfunction

endpackage

// File: rtl/processor_stage2_v2_fwd_select.sv
// Priority forward mux for one register read port; the lowest-index matching source wins.
module fwd_select #(
  parameter int WORD_SIZE     = 18,
  parameter int REG_ADDR_BITS = 3,
  parameter int FWD_PORTS     = 2
) (
  input  logic [REG_ADDR_BITS-1:0]           addr,
  input  logic [WORD_SIZE-1:0]               reg_data,
  input  logic [FWD_PORTS-1:0]               fwd_enable,
  input  logic [FWD_PORTS*REG_ADDR_BITS-1:0] fwd_addr,
  input  logic [FWD_PORTS*WORD_SIZE-1:0]     fwd_data,
  output logic [WORD_SIZE-1:0]               data
);

  // Scanning from the oldest source down lets the youngest match overwrite last.
  always_comb begin
    data = reg_data;
    for (int i = FWD_PORTS - 1; i >= 0; i--) begin
      if (fwd_enable[i] && (fwd_addr[i*REG_ADDR_BITS +: REG_ADDR_BITS] == addr))
        data = fwd_data[i*WORD_SIZE +: WORD_SIZE];
    end
  end

endmodule

// File: rtl/processor_stage2_v2_if_control.sv
// Condition evaluator for IF: tests a register value against a 3-bit condition code.
module if_control #(
  parameter int WORD_SIZE = 18
) (
  input  logic [WORD_SIZE-1:0] data,
  input  logic [2:0]           cond,
  output logic                 ok
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (data == '0);
  assign is_neg  = data[WORD_SIZE-1];

  always_comb begin
    ok = 1'b0;
    case (cond)
      3'd0:    ok = 1'b1;
      3'd1:    ok = is_zero;
      3'd2:    ok = !is_zero;
      3'd3:    ok = is_neg;
      3'd4:    ok = !is_neg;
      3'd5:    ok = !is_neg && !is_zero;
      3'd6:    ok = is_neg || is_zero;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/processor_stage2_v2.sv
// Operand-fetch stage: register read with forwarding, load-use interlock, memory issue,
// branch/call/return resolution and timed or event-driven WAIT.
//   state      | meaning
//   RUN        | instructions issue normally
//   WAIT_TIMED | counting down imm8 cycles, stage1 held, bubbles emitted
//   WAIT_EVENT | held until wake, bubbles emitted
module processor_stage2_v2
  import processor_pkg::*;
#(
  parameter int ADDR_SIZE     = 18,
  parameter int WORD_SIZE     = 18,
  parameter int REG_ADDR_BITS = 3,
  parameter int FWD_PORTS     = 2,
  parameter int WAIT_CNT_BITS = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               no_operation,
  input  logic [ADDR_SIZE-1:0]               ip,
  input  logic [ADDR_SIZE-1:0]               ip_plus_one,
  input  logic [WORD_SIZE-1:0]               code_word,
  output logic                               stall_out,
  output logic [ADDR_SIZE-1:0]               memory_addr,
  output logic                               memory_write_enable,
  output logic [WORD_SIZE-1:0]               memory_in,
  output logic [REG_ADDR_BITS-1:0]           reg_read_addr0,
  output logic [REG_ADDR_BITS-1:0]           reg_read_addr1,
  input  logic [WORD_SIZE-1:0]               reg_read_data0,
  input  logic [WORD_SIZE-1:0]               reg_read_data1,
  input  logic [FWD_PORTS-1:0]               fwd_enable,
  input  logic [FWD_PORTS*REG_ADDR_BITS-1:0] fwd_addr,
  input  logic [FWD_PORTS*WORD_SIZE-1:0]     fwd_data,
  input  logic                               ex_load_pending,
  input  logic [REG_ADDR_BITS-1:0]           ex_load_addr,
  input  logic                               wake,
  output logic                               no_operation_out,
  output logic [WORD_SIZE-1:0]               alu_data0_out,
  output logic [WORD_SIZE-1:0]               alu_data1_out,
  output logic [WORD_SIZE-1:0]               code_word_out,
  output logic [ADDR_SIZE-1:0]               data1_plus_imm8_out,
  output logic                               waiting_global,
  output logic [ADDR_SIZE-1:0]               ip_to_call,
  output logic                               call_performed,
  output logic                               return_performed
);

  localparam logic [REG_ADDR_BITS-1:0] SP = '1;

  stage2_state_t             state;
  logic [WAIT_CNT_BITS-1:0]  wait_cnt;
  logic [ADDR_SIZE-1:0]      ip_reg;
  logic [ADDR_SIZE-1:0]      ip_plus_one_reg;

  logic [3:0]                op;
  logic [REG_ADDR_BITS-1:0]  rx;
  logic [REG_ADDR_BITS-1:0]  ry;
  logic [7:0]                imm8;
  logic [ADDR_SIZE-1:0]      simm8;
  logic [WORD_SIZE-1:0]      data0;
  logic [WORD_SIZE-1:0]      data1;
  logic [ADDR_SIZE-1:0]      data1_addr;
  logic [ADDR_SIZE-1:0]      eff_addr;
  logic                      running;
  logic                      hazard;
  logic                      issue;
  logic                      cond_ok;
  logic                      is_call;
  logic                      is_sp_op;

  assign op    = code_word[17:14];
  assign rx    = code_word[13:11];
  assign ry    = code_word[10:8];
  assign imm8  = code_word[7:0];
  assign simm8 = {{(ADDR_SIZE-8){imm8[7]}}, imm8};

  assign is_call  = (op == OP_CALL_IMM14);
  assign is_sp_op = is_call || (op == OP_RETURN);

  assign reg_read_addr0 = rx;
  assign reg_read_addr1 = is_sp_op ? SP : ry;

  fwd_select #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_BITS(REG_ADDR_BITS), .FWD_PORTS(FWD_PORTS)) u_fwd0 (
    .addr(reg_read_addr0), .reg_data(reg_read_data0), .fwd_enable(fwd_enable),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .data(data0)
  );

  fwd_select #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_BITS(REG_ADDR_BITS), .FWD_PORTS(FWD_PORTS)) u_fwd1 (
    .addr(reg_read_addr1), .reg_data(reg_read_data1), .fwd_enable(fwd_enable),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .data(data1)
  );

  if_control #(.WORD_SIZE(WORD_SIZE)) u_if (
    .data(data0), .cond(ry), .ok(cond_ok)
  );

  assign data1_addr = ADDR_SIZE'(data1);
  assign eff_addr   = data1_addr + simm8;

  assign running = (state == RUN);
  assign hazard  = running && !no_operation && ex_load_pending &&
                   ((uses_port0(op) && (ex_load_addr == reg_read_addr0)) ||
                    (uses_port1(op) && (ex_load_addr == reg_read_addr1)));
  assign issue   = running && !no_operation && !hazard;

  assign stall_out      = hazard || !running;
  assign waiting_global = !running;

  assign call_performed      = issue && (is_call || ((op == OP_IF) && cond_ok));
  assign ip_to_call          = is_call ? ADDR_SIZE'(code_word[13:0]) : ip_reg + simm8;
  assign memory_write_enable = issue && ((op == OP_WRITE) || is_call);
  assign memory_addr         = is_sp_op ? data1_addr : eff_addr;
  assign memory_in           = is_call ? WORD_SIZE'(ip_plus_one_reg) : data0;

  // ip_reg tracks the address of the word now on code_word; it freezes whenever stage1 is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ip_reg              <= '0;
      ip_plus_one_reg     <= '0;
      no_operation_out    <= 1'b1;
      return_performed    <= 1'b0;
      alu_data0_out       <= '0;
      alu_data1_out       <= '0;
      code_word_out       <= '0;
      data1_plus_imm8_out <= '0;
    end else begin
      if (!stall_out) begin
        ip_reg          <= ip;
        ip_plus_one_reg <= ip_plus_one;
      end
      no_operation_out    <= !issue || (op == OP_WAIT);
      return_performed    <= issue && (op == OP_RETURN);
      alu_data0_out       <= data0;
      alu_data1_out       <= data1;
      code_word_out       <= code_word;
      data1_plus_imm8_out <= eff_addr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (issue && (op == OP_WAIT)) begin
            if (imm8 != 8'd0) begin
              state    <= WAIT_TIMED;
              wait_cnt <= WAIT_CNT_BITS'(imm8);
            end else begin
              state <= WAIT_EVENT;
            end
          end
        end
        WAIT_TIMED: begin
          if (wait_cnt == WAIT_CNT_BITS'(1)) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        WAIT_EVENT: begin
          if (wake) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_processor_stage2_v2.sv
// Directed bench for processor_stage2_v2: table of single-instruction vectors plus
// hand-written sequences for interlock, WAIT and reset behaviour.
module tb_processor_stage2_v2;

  logic        clock;
  logic        reset;
  logic        no_operation;
  logic [17:0] ip, ip_plus_one, code_word;
  logic        stall_out;
  logic [17:0] memory_addr;
  logic        memory_write_enable;
  logic [17:0] memory_in;
  logic [2:0]  reg_read_addr0, reg_read_addr1;
  logic [17:0] reg_read_data0, reg_read_data1;
  logic [1:0]  fwd_enable;
  logic [5:0]  fwd_addr;
  logic [35:0] fwd_data;
  logic        ex_load_pending;
  logic [2:0]  ex_load_addr;
  logic        wake;
  logic        no_operation_out;
  logic [17:0] alu_data0_out, alu_data1_out, code_word_out, data1_plus_imm8_out;
  logic        waiting_global;
  logic [17:0] ip_to_call;
  logic        call_performed;
  logic        return_performed;

  logic [17:0] regs [8];
  assign reg_read_data0 = regs[reg_read_addr0];
  assign reg_read_data1 = regs[reg_read_addr1];

  int tests = 0;
  int fails = 0;

  processor_stage2_v2 dut (
    .clock(clock), .reset(reset), .no_operation(no_operation), .ip(ip), .ip_plus_one(ip_plus_one),
    .code_word(code_word), .stall_out(stall_out), .memory_addr(memory_addr),
    .memory_write_enable(memory_write_enable), .memory_in(memory_in),
    .reg_read_addr0(reg_read_addr0), .reg_read_addr1(reg_read_addr1),
    .reg_read_data0(reg_read_data0), .reg_read_data1(reg_read_data1),
    .fwd_enable(fwd_enable), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .ex_load_pending(ex_load_pending), .ex_load_addr(ex_load_addr), .wake(wake),
    .no_operation_out(no_operation_out), .alu_data0_out(alu_data0_out), .alu_data1_out(alu_data1_out),
    .code_word_out(code_word_out), .data1_plus_imm8_out(data1_plus_imm8_out),
    .waiting_global(waiting_global), .ip_to_call(ip_to_call), .call_performed(call_performed),
    .return_performed(return_performed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        nop;
    logic [17:0] ip;
    logic [17:0] cw;
    logic [1:0]  fen;
    logic [5:0]  fa;
    logic [35:0] fd;
    logic        ldp;
    logic [2:0]  lda;
    logic        e_stall;
    logic        e_we;
    logic        chk_mem;
    logic [17:0] e_maddr;
    logic [17:0] e_min;
    logic        e_call;
    logic [17:0] e_tgt;
    logic        e_nop;
    logic        chk_ops;
    logic [17:0] e_d0;
    logic [17:0] e_d1;
    logic [17:0] e_di;
    logic        e_ret;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] mk(input logic [3:0] op, input logic [2:0] rx,
                                     input logic [2:0] ry, input logic [7:0] imm);
    return {op, rx, ry, imm};
  endfunction

  function automatic vec_t v(input logic nop, input logic [17:0] vip, input logic [17:0] cw,
                             input logic [1:0] fen, input logic [5:0] fa, input logic [35:0] fd,
                             input logic ldp, input logic [2:0] lda, input logic st, input logic we,
                             input logic cm, input logic [17:0] ma, input logic [17:0] mi,
                             input logic cl, input logic [17:0] tg, input logic en, input logic co,
                             input logic [17:0] d0, input logic [17:0] d1, input logic [17:0] di,
                             input logic rt);
    vec_t r;
    r.nop = nop; r.ip = vip; r.cw = cw; r.fen = fen; r.fa = fa; r.fd = fd; r.ldp = ldp; r.lda = lda;
    r.e_stall = st; r.e_we = we; r.chk_mem = cm; r.e_maddr = ma; r.e_min = mi; r.e_call = cl;
    r.e_tgt = tg; r.e_nop = en; r.chk_ops = co; r.e_d0 = d0; r.e_d1 = d1; r.e_di = di; r.e_ret = rt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic nop, input logic [17:0] vip, input logic [17:0] cw);
    no_operation = nop;
    ip           = vip;
    ip_plus_one  = vip + 18'd1;
    code_word    = cw;
  endtask

  task automatic clear_side();
    fwd_enable = 2'b00; fwd_addr = '0; fwd_data = '0;
    ex_load_pending = 1'b0; ex_load_addr = '0; wake = 1'b0;
  endtask

  int cnt;
  int first_issue;
  int bubbles;
  bit seen_issue;

  initial begin
    regs[0] = 18'h0;     regs[1] = 18'h5;  regs[2] = 18'h10; regs[3] = 18'h20;
    regs[4] = 18'h3;     regs[5] = 18'h3FFFF; regs[6] = 18'h0; regs[7] = 18'h100;

    // nop ip cw fen fa fd ldp lda | stall we chkmem maddr min call tgt nop chkops d0 d1 di ret
    vecs.push_back(v(0, 18'h10, mk(1,2,1,0), 2'b11, {3'd1,3'd1}, {18'd7,18'd9}, 0, 0,
                     0,0,0,0,0, 0,0, 0,1, 18'h10, 18'd9, 18'd9, 0));
    vecs.push_back(v(0, 18'h10, mk(1,2,1,0), 2'b10, {3'd1,3'd1}, {18'd7,18'd9}, 0, 0,
                     0,0,0,0,0, 0,0, 0,1, 18'h10, 18'd7, 18'd7, 0));
    vecs.push_back(v(0, 18'h10, mk(1,2,1,0), 2'b11, {3'd1,3'd3}, {18'd7,18'h55}, 0, 0,
                     0,0,0,0,0, 0,0, 0,1, 18'h10, 18'd7, 18'd7, 0));
    vecs.push_back(v(0, 18'h10, mk(1,2,1,0), 2'b01, {3'd0,3'd2}, {18'd0,18'h77}, 0, 0,
                     0,0,0,0,0, 0,0, 0,1, 18'h77, 18'd5, 18'd5, 0));
    vecs.push_back(v(0, 18'h10, mk(3,4,3,8'hFE), 0, 0, 0, 0, 0,
                     0,1,1,18'h1E,18'h3, 0,0, 0,1, 18'h3, 18'h20, 18'h1E, 0));
    vecs.push_back(v(0, 18'h10, mk(3,1,0,8'h80), 0, 0, 0, 0, 0,
                     0,1,1,18'h3FF80,18'h5, 0,0, 0,1, 18'h5, 18'h0, 18'h3FF80, 0));
    vecs.push_back(v(0, 18'h10, mk(2,0,2,8'h04), 0, 0, 0, 0, 0,
                     0,0,0,0,0, 0,0, 0,1, 18'h0, 18'h10, 18'h14, 0));
    vecs.push_back(v(0, 18'h40, mk(4,0,1,8'h10), 0, 0, 0, 0, 0,
                     0,0,0,0,0, 1,18'h50, 0,0, 0,0,0, 0));
    vecs.push_back(v(0, 18'h40, mk(4,1,1,8'h10), 0, 0, 0, 0, 0,
                     0,0,0,0,0, 0,0, 0,0, 0,0,0, 0));
    vecs.push_back(v(0, 18'h40, mk(4,5,3,8'hF0), 0, 0, 0, 0, 0,
                     0,0,0,0,0, 1,18'h30, 0,0, 0,0,0, 0));
    vecs.push_back(v(0, 18'h3FFF8, mk(4,0,0,8'h10), 0, 0, 0, 0, 0,
                     0,0,0,0,0, 1,18'h8, 0,0, 0,0,0, 0));
    vecs.push_back(v(0, 18'h40, 18'h15234, 0, 0, 0, 0, 0,
                     0,1,1,18'h100,18'h41, 1,18'h1234, 0,0, 0,0,0, 0));
    vecs.push_back(v(1, 18'h40, 18'h15234, 0, 0, 0, 1, 3'd7,
                     0,0,0,0,0, 0,0, 1,0, 0,0,0, 0));
    vecs.push_back(v(0, 18'h40, mk(1,4,3,0), 0, 0, 0, 1, 3'd3,
                     1,0,0,0,0, 0,0, 1,0, 0,0,0, 0));
    vecs.push_back(v(0, 18'h40, mk(1,4,2,0), 0, 0, 0, 1, 3'd3,
                     0,0,0,0,0, 0,0, 0,1, 18'h3, 18'h10, 18'h10, 0));
    vecs.push_back(v(0, 18'h40, 18'h15234, 0, 0, 0, 1, 3'd7,
                     1,0,0,0,0, 0,0, 1,0, 0,0,0, 0));
    vecs.push_back(v(0, 18'h40, mk(3,4,2,0), 0, 0, 0, 1, 3'd4,
                     1,0,0,0,0, 0,0, 1,0, 0,0,0, 0));
    vecs.push_back(v(0, 18'h40, mk(6,0,0,0), 0, 0, 0, 0, 0,
                     0,0,0,0,0, 0,0, 0,0, 0,0,0, 1));
    vecs.push_back(v(0, 18'h40, mk(1,2,1,0), 0, 0, 0, 0, 0,
                     0,0,0,0,0, 0,0, 0,1, 18'h10, 18'h5, 18'h5, 0));
    vecs.push_back(v(1, 18'h40, mk(7,0,0,8'h05), 0, 0, 0, 0, 0,
                     0,0,0,0,0, 0,0, 1,0, 0,0,0, 0));
    vecs.push_back(v(0, 18'h40, mk(1,2,1,0), 0, 0, 0, 0, 0,
                     0,0,0,0,0, 0,0, 0,1, 18'h10, 18'h5, 18'h5, 0));

    // Reset state
    reset = 1'b0;
    clear_side();
    drive(1'b1, 18'h0, 18'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst no_operation_out", no_operation_out, 1);
    chk("rst return_performed", return_performed, 0);
    chk("rst waiting_global", waiting_global, 0);
    chk("rst alu_data0_out", alu_data0_out, 0);
    chk("rst alu_data1_out", alu_data1_out, 0);
    chk("rst code_word_out", code_word_out, 0);
    chk("rst data1_plus_imm8_out", data1_plus_imm8_out, 0);
    chk("rst stall_out", stall_out, 0);
    @(negedge clock);
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].nop, vecs[i].ip, vecs[i].cw);
      fwd_enable = vecs[i].fen; fwd_addr = vecs[i].fa; fwd_data = vecs[i].fd;
      ex_load_pending = vecs[i].ldp; ex_load_addr = vecs[i].lda;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d stall_out", i), stall_out, vecs[i].e_stall);
      chk($sformatf("v%0d memory_write_enable", i), memory_write_enable, vecs[i].e_we);
      chk($sformatf("v%0d call_performed", i), call_performed, vecs[i].e_call);
      chk($sformatf("v%0d no_operation_out", i), no_operation_out, vecs[i].e_nop);
      chk($sformatf("v%0d return_performed", i), return_performed, vecs[i].e_ret);
      if (vecs[i].chk_mem) begin
        chk($sformatf("v%0d memory_addr", i), memory_addr, vecs[i].e_maddr);
        chk($sformatf("v%0d memory_in", i), memory_in, vecs[i].e_min);
      end
      if (vecs[i].e_call)
        chk($sformatf("v%0d ip_to_call", i), ip_to_call, vecs[i].e_tgt);
      if (vecs[i].chk_ops) begin
        chk($sformatf("v%0d alu_data0_out", i), alu_data0_out, vecs[i].e_d0);
        chk($sformatf("v%0d alu_data1_out", i), alu_data1_out, vecs[i].e_d1);
        chk($sformatf("v%0d data1_plus_imm8_out", i), data1_plus_imm8_out, vecs[i].e_di);
      end
    end

    // Load-use: one stall cycle, one bubble, then the instruction issues
    @(negedge clock);
    clear_side();
    drive(1'b0, 18'h20, mk(1,4,3,0));
    ex_load_pending = 1'b1; ex_load_addr = 3'd3;
    cnt = 0; bubbles = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clock);
      if (c == 1) ex_load_pending = 1'b0;
      if (c == 2) no_operation = 1'b1;
      if (stall_out) cnt++;
      @(posedge clock);
      #1;
      if (c < 2 && no_operation_out) bubbles++;
      if (c == 1) chk("loaduse alu_data1_out", alu_data1_out, 18'h20);
    end
    chk("loaduse stall cycles", cnt, 1);
    chk("loaduse bubbles", bubbles, 1);

    // WAIT imm8=3: waiting for 3 cycles, ip_reg frozen, next instruction on edge 4
    @(negedge clock);
    clear_side();
    drive(1'b0, 18'h60, mk(7,0,0,8'd3));
    @(posedge clock);
    #1;
    chk("wait3 wait bubble", no_operation_out, 1);
    cnt = 0; first_issue = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (c == 1) drive(1'b0, 18'h3AAAA, mk(4,0,0,8'd5));
      if (waiting_global) begin
        cnt++;
        chk($sformatf("wait3 c%0d call_performed", c), call_performed, 0);
        chk($sformatf("wait3 c%0d stall_out", c), stall_out, 1);
      end
      if (c == 4) begin
        chk("wait3 resume call_performed", call_performed, 1);
        chk("wait3 frozen ip target", ip_to_call, 18'h65);
      end
      @(posedge clock);
      #1;
      if (!no_operation_out && first_issue == 0) first_issue = c;
    end
    chk("wait3 waiting cycles", cnt, 3);
    chk("wait3 first issue edge", first_issue, 4);

    // WAIT imm8=1: exactly one extra bubble after the WAIT bubble
    @(negedge clock);
    drive(1'b0, 18'h70, mk(7,0,0,8'd1));
    bubbles = 0; seen_issue = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clock);
      if (c == 1) drive(1'b0, 18'h71, mk(1,2,1,0));
      @(posedge clock);
      #1;
      if (no_operation_out && !seen_issue) bubbles++;
      if (!no_operation_out) seen_issue = 1;
    end
    chk("wait1 bubbles", bubbles, 2);

    // Event WAIT: an early wake is ignored; wake at cycle 10 releases at cycle 11
    @(negedge clock);
    drive(1'b0, 18'h80, mk(1,2,1,0));
    wake = 1'b1;
    @(negedge clock);
    wake = 1'b0;
    drive(1'b0, 18'h81, mk(7,0,0,8'd0));
    @(posedge clock);
    cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) drive(1'b0, 18'h82, mk(1,2,1,0));
      wake = (c == 10);
      if (waiting_global) cnt++;
      if (c == 1) chk("wevent entered despite early wake", waiting_global, 1);
      if (c == 10) chk("wevent c10 waiting", waiting_global, 1);
      if (c == 11) chk("wevent c11 running", waiting_global, 0);
      @(posedge clock);
      #1;
      if (c == 11) chk("wevent c11 issue", no_operation_out, 0);
    end
    chk("wevent waiting cycles", cnt, 10);

    // Async reset in the middle of a long timed WAIT
    @(negedge clock);
    wake = 1'b0;
    drive(1'b0, 18'h90, mk(7,0,0,8'd200));
    repeat (4) @(negedge clock);
    drive(1'b0, 18'h91, mk(1,2,1,0));
    chk("rstwait waiting before reset", waiting_global, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rstwait waiting_global", waiting_global, 0);
    chk("rstwait no_operation_out", no_operation_out, 1);
    chk("rstwait alu_data1_out", alu_data1_out, 0);
    chk("rstwait code_word_out", code_word_out, 0);
    chk("rstwait return_performed", return_performed, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rstwait issue after release", no_operation_out, 0);
    chk("rstwait alu_data1_out after", alu_data1_out, 18'h5);
    chk("rstwait still running", waiting_global, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
